// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: mode encodings and per-mode polynomial length, tap and state mask.
package prbs_pkg;

  localparam int unsigned PRBS_STATE_W = 31;
  localparam int unsigned PRBS_MODE_W  = 3;

  localparam logic [PRBS_MODE_W-1:0] PRBS_MODE_7  = 3'd0;
  localparam logic [PRBS_MODE_W-1:0] PRBS_MODE_9  = 3'd1;
  localparam logic [PRBS_MODE_W-1:0] PRBS_MODE_15 = 3'd2;
  localparam logic [PRBS_MODE_W-1:0] PRBS_MODE_23 = 3'd3;
  localparam logic [PRBS_MODE_W-1:0] PRBS_MODE_31 = 3'd4;

  localparam logic [PRBS_STATE_W-1:0] PRBS_SEED_ONES = 31'h7FFF_FFFF;

  // Polynomial length L; unused encodings fall back to PRBS7.
  function automatic logic [4:0] prbs_len(input logic [PRBS_MODE_W-1:0] mode);
    case (mode)
      PRBS_MODE_9:  prbs_len = 5'd9;
      PRBS_MODE_15: prbs_len = 5'd15;
      PRBS_MODE_23: prbs_len = 5'd23;
      PRBS_MODE_31: prbs_len = 5'd31;
      default:      prbs_len = 5'd7;
    endcase
  endfunction

  function automatic logic [4:0] prbs_tap(input logic [PRBS_MODE_W-1:0] mode);
    case (mode)
      PRBS_MODE_9:  prbs_tap = 5'd5;
      PRBS_MODE_15: prbs_tap = 5'd14;
      PRBS_MODE_23: prbs_tap = 5'd18;
      PRBS_MODE_31: prbs_tap = 5'd28;
      default:      prbs_tap = 5'd6;
    endcase
  endfunction

  function automatic logic [PRBS_STATE_W-1:0] prbs_mask(input logic [PRBS_MODE_W-1:0] mode);
    case (mode)
      PRBS_MODE_9:  prbs_mask = 31'h0000_01FF;
      PRBS_MODE_15: prbs_mask = 31'h0000_7FFF;
      PRBS_MODE_23: prbs_mask = 31'h007F_FFFF;
      PRBS_MODE_31: prbs_mask = PRBS_SEED_ONES;
      default:      prbs_mask = 31'h0000_007F;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr_unroll.sv
// Combinational NBITS-step Fibonacci LFSR advance; bits[k] is the k-th generated bit.
module prbs_lfsr_unroll
  import prbs_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic [PRBS_STATE_W-1:0] state,
  input  logic [PRBS_MODE_W-1:0]  mode,
  output logic [PRBS_STATE_W-1:0] next_state,
  output logic [NBITS-1:0]        bits
);

  logic [PRBS_STATE_W-1:0] mask;
  logic [PRBS_STATE_W-1:0] s;
  logic [4:0]              len;
  logic [4:0]              tap;
  logic                    nb;

  always_comb begin
    mask = prbs_mask(mode);
    len  = prbs_len(mode);
    tap  = prbs_tap(mode);
    s    = state & mask;
    nb   = 1'b0;
    bits = '0;
    for (int unsigned k = 0; k < NBITS; k++) begin
      nb      = s[len - 5'd1] ^ s[tap - 5'd1];
      bits[k] = nb;
      s       = ((s << 1) | PRBS_STATE_W'(nb)) & mask;
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_gen_parallel_multi.sv
// Parallel multi-polynomial PRBS generator with seed reload, bit-order select,
// single-bit error injection and a saturating emitted-word counter.
module prbs_gen_parallel_multi
  import prbs_pkg::*;
#(
  parameter int unsigned           NBITS    = 8,
  parameter int unsigned           CNT_W    = 32,
  parameter logic [PRBS_MODE_W-1:0] DEF_MODE = 3'd0
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    prbs_en_i,
  input  logic                    clear_i,
  input  logic [PRBS_MODE_W-1:0]  mode_i,
  input  logic [PRBS_STATE_W-1:0] seed_i,
  input  logic                    msb_first_i,
  input  logic                    inj_err_i,
  output logic [NBITS-1:0]        prbs_data_o,
  output logic                    prbs_valid_o,
  output logic [CNT_W-1:0]        word_cnt_o,
  output logic                    err_inj_ack_o
);

  logic [PRBS_STATE_W-1:0] state_q, state_d, state_nxt, mask_q, mask_new, seed_m;
  logic [PRBS_MODE_W-1:0]  mode_q, mode_d;
  logic [NBITS-1:0]        gen_bits, word, data_d;
  logic [CNT_W-1:0]        cnt_d;
  logic                    valid_d, ack_d, pend_q, pend_d, reload, lockup;

  prbs_lfsr_unroll #(.NBITS(NBITS)) u_unroll (
    .state      (state_q),
    .mode       (mode_q),
    .next_state (state_nxt),
    .bits       (gen_bits)
  );

  // Place generated bits according to the requested bit order.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < NBITS; k++) begin
      if (msb_first_i) word[NBITS-1-k] = gen_bits[k];
      else             word[k]         = gen_bits[k];
    end
  end

  // A mode change behaves exactly like a clear using the incoming mode's length.
  always_comb begin
    mask_q   = prbs_mask(mode_q);
    mask_new = prbs_mask(mode_i);
    seed_m   = seed_i & mask_new;
    reload   = clear_i || (mode_i != mode_q);
    lockup   = prbs_en_i && ((state_q & mask_q) == '0);

    state_d  = state_q;
    mode_d   = mode_q;
    data_d   = prbs_data_o;
    valid_d  = 1'b0;
    cnt_d    = word_cnt_o;
    ack_d    = 1'b0;
    pend_d   = pend_q | inj_err_i;

    if (reload) begin
      state_d = (seed_m == '0) ? mask_new : seed_m;
      mode_d  = mode_i;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (lockup) begin
      state_d = mask_q;
    end else if (prbs_en_i) begin
      state_d = state_nxt;
      data_d  = word ^ NBITS'(pend_q);
      valid_d = 1'b1;
      ack_d   = pend_q;
      pend_d  = pend_q ? 1'b0 : inj_err_i;
      cnt_d   = (&word_cnt_o) ? word_cnt_o : word_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= PRBS_SEED_ONES & prbs_mask(DEF_MODE);
      mode_q        <= DEF_MODE;
      prbs_data_o   <= '0;
      prbs_valid_o  <= 1'b0;
      word_cnt_o    <= '0;
      err_inj_ack_o <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      prbs_data_o   <= data_d;
      prbs_valid_o  <= valid_d;
      word_cnt_o    <= cnt_d;
      err_inj_ack_o <= ack_d;
      pend_q        <= pend_d;
    end
  end

endmodule

// File: tb/tb_prbs_gen_parallel_multi.sv
// Directed bench for prbs_gen_parallel_multi: an 8-bit instance and a 7-bit/4-bit-counter instance.
module tb_prbs_gen_parallel_multi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en, clr, msb, inj;
  logic [2:0]  mode;
  logic [30:0] seed;
  logic [7:0]  data;
  logic        valid, ack;
  logic [31:0] cnt;

  logic        en7, clr7, msb7, inj7;
  logic [2:0]  mode7;
  logic [30:0] seed7;
  logic [6:0]  data7;
  logic        valid7, ack7;
  logic [3:0]  cnt7;

  int          n_cmp = 0;
  int          n_err = 0;

  logic [30:0] ms;
  logic [2:0]  mmode;
  logic [31:0] ew;
  logic [7:0]  last;
  int          exp_cnt;
  logic [6:0]  w7 [0:127];
  bit          seen [0:127];
  int          distinct;

  always #5 clk = ~clk;

  prbs_gen_parallel_multi #(.NBITS(8), .CNT_W(32), .DEF_MODE(3'd0)) u_dut (
    .clk_i(clk), .resetn_i(resetn), .prbs_en_i(en), .clear_i(clr), .mode_i(mode),
    .seed_i(seed), .msb_first_i(msb), .inj_err_i(inj), .prbs_data_o(data),
    .prbs_valid_o(valid), .word_cnt_o(cnt), .err_inj_ack_o(ack)
  );

  prbs_gen_parallel_multi #(.NBITS(7), .CNT_W(4), .DEF_MODE(3'd0)) u_dut7 (
    .clk_i(clk), .resetn_i(resetn), .prbs_en_i(en7), .clear_i(clr7), .mode_i(mode7),
    .seed_i(seed7), .msb_first_i(msb7), .inj_err_i(inj7), .prbs_data_o(data7),
    .prbs_valid_o(valid7), .word_cnt_o(cnt7), .err_inj_ack_o(ack7)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial reference LFSR: w bits from state st for polynomial md.
  function automatic logic [31:0] mdl(input int w, input logic msb_f, input logic [2:0] md,
                                      inout logic [30:0] st);
    int          len, tap;
    logic        nb;
    logic [31:0] r;
    logic [30:0] msk;
    case (md)
      3'd1:    begin len = 9;  tap = 5;  end
      3'd2:    begin len = 15; tap = 14; end
      3'd3:    begin len = 23; tap = 18; end
      3'd4:    begin len = 31; tap = 28; end
      default: begin len = 7;  tap = 6;  end
    endcase
    msk = 31'h7FFF_FFFF >> (31 - len);
    r   = '0;
    for (int k = 0; k < w; k++) begin
      nb = st[len-1] ^ st[tap-1];
      st = ((st << 1) | 31'(nb)) & msk;
      if (msb_f) r[w-1-k] = nb;
      else       r[k]     = nb;
    end
    return r;
  endfunction

  task automatic emit_chk(input string tag, input logic flip);
    ew = mdl(8, msb, mmode, ms);
    exp_cnt++;
    chk({tag, "_data"}, 64'(data), 64'(ew[7:0] ^ {7'd0, flip}));
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    chk({tag, "_ack"}, 64'(ack), 64'(flip));
    last = data;
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; clr = 1'b0; msb = 1'b1; inj = 1'b0; mode = 3'd0; seed = '0;
    en7 = 1'b0; clr7 = 1'b0; msb7 = 1'b1; inj7 = 1'b0; mode7 = 3'd0; seed7 = '0;
    #12;
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    resetn = 1'b1;
    en = 1'b1;

    // Hand-computed PRBS7 words from all-ones, msb first.
    step();
    chk("w1_msb", 64'(data), 64'h02);
    chk("w1_valid", 64'(valid), 64'd1);
    chk("w1_cnt", 64'(cnt), 64'd1);
    step();
    chk("w2_msb", 64'(data), 64'h0C);
    chk("w2_cnt", 64'(cnt), 64'd2);

    // Asynchronous reset mid-stream.
    resetn = 1'b0;
    #1;
    chk("arst_data", 64'(data), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    msb = 1'b0;
    resetn = 1'b1;
    step();
    chk("w1_lsb", 64'(data), 64'h40);
    step();
    chk("w2_lsb", 64'(data), 64'h30);
    chk("w2_lsb_cnt", 64'(cnt), 64'd2);
    ms = 31'h7F; mmode = 3'd0; exp_cnt = 2;
    ew = mdl(8, 1'b0, mmode, ms);
    ew = mdl(8, 1'b0, mmode, ms);

    // Bit order flip mid-stream.
    msb = 1'b1;
    step();
    emit_chk("order_flip", 1'b0);

    // Injection requested while idle.
    en = 1'b0; inj = 1'b1;
    step();
    chk("inj_idle_valid", 64'(valid), 64'd0);
    chk("inj_idle_data", 64'(data), 64'(last));
    inj = 1'b0; en = 1'b1;
    step();
    emit_chk("inj_word", 1'b1);
    step();
    emit_chk("inj_after", 1'b0);

    // Injection coincident with an emitted word applies to the next one.
    inj = 1'b1;
    step();
    emit_chk("inj_coinc", 1'b0);
    inj = 1'b0;
    step();
    emit_chk("inj_coinc_next", 1'b1);

    // Second request while pending is dropped.
    en = 1'b0; inj = 1'b1;
    step();
    step();
    inj = 1'b0; en = 1'b1;
    step();
    emit_chk("inj_pend", 1'b1);
    step();
    emit_chk("inj_pend_after", 1'b0);
    chk("cnt_run", 64'(cnt), 64'(exp_cnt));

    // Disabled cycle holds data and count.
    en = 1'b0;
    step();
    chk("hold_valid", 64'(valid), 64'd0);
    chk("hold_data", 64'(data), 64'(last));
    chk("hold_cnt", 64'(cnt), 64'(exp_cnt));

    // Clear with zero seed restarts the reset stream.
    en = 1'b1; clr = 1'b1; seed = '0;
    step();
    chk("clr_valid", 64'(valid), 64'd0);
    chk("clr_cnt", 64'(cnt), 64'd0);
    clr = 1'b0;
    step();
    chk("clr_w1", 64'(data), 64'h02);
    chk("clr_w1_cnt", 64'(cnt), 64'd1);
    step();
    chk("clr_w2", 64'(data), 64'h0C);

    // Mode switch to PRBS31 with a seed.
    mode = 3'd4; seed = 31'h1234_5678;
    step();
    chk("mode_valid", 64'(valid), 64'd0);
    chk("mode_cnt", 64'(cnt), 64'd0);
    ms = 31'h1234_5678; mmode = 3'd4; exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      emit_chk("prbs31", 1'b0);
    end
    chk("prbs31_cnt", 64'(cnt), 64'd4);
    en = 1'b0;

    // 7-bit instance: full PRBS7 period and counter saturation.
    en7 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      step();
      w7[i] = data7;
    end
    en7 = 1'b0;
    chk("p7_w1", 64'(w7[0]), 64'h01);
    chk("p7_wrap", 64'(w7[127]), 64'(w7[0]));
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int i = 0; i < 127; i++) begin
      if (!seen[w7[i]] && w7[i] != 7'd0) distinct++;
      seen[w7[i]] = 1'b1;
    end
    chk("p7_distinct", 64'(distinct), 64'd127);
    chk("p7_cnt_sat", 64'(cnt7), 64'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
